dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Memory-side responder for the dCPU bus. It serves the CPU's active-low R/W strobes from a 256x8 RAM. It streams a program image into RAM while holding the CPU in reset, then releases it. It maps one address to a byte-output FIFO with a status readback.

Parameters:
OUT_DEPTH, 4, output FIFO depth; legal values 2 or 4.
MMIO_ADDR, 8'hFF, address of the output port / status register.
LOAD_EN, 1, 1 = start in LOAD after reset; 0 = start directly in RUN.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
R  input  1  CPU read strobe, active low.
W  input  1  CPU write strobe, active low.
addr  input  8  CPU address.
data_in  input  8  write data from CPU.
data_out  output  8  read data to CPU (drives CPU mem_in).
cpu_rst  output  1  reset to CPU, active high.
load_valid  input  1  loader byte valid.
load_data  input  8  loader byte.
load_last  input  1  marks final loader byte.
load_ready  output  1  responder accepts a loader byte.
out_valid  output  1  FIFO non-empty.
out_data  output  8  FIFO head byte.
out_ready  input  1  consumer pops the head when out_valid is high.
err  output  1  sticky flag: R and W were both low in RUN.
ovf  output  1  sticky flag: a write was made to a full FIFO.

Behaviour:
- FSM states: LOAD, RELEASE, RUN.
- Reset, asynchronous: state = LOAD if LOAD_EN else RUN; load_ptr=0; FIFO emptied; err=0; ovf=0.
- RAM contents are not touched by rst. Reset mid-load restarts the load at address 0.
- Output reset values: cpu_rst=1 (0 if LOAD_EN=0), load_ready=LOAD_EN, out_valid=0, out_data=0, data_out=0, err=0, ovf=0.
- LOAD state:
  - cpu_rst=1, load_ready=1, data_out=0, CPU strobes ignored.
  - Each cycle with load_valid=1: ram[load_ptr]<=load_data, load_ptr<=load_ptr+1.
  - Go to RELEASE if load_last=1, or if load_ptr==255 (256th byte, ptr wraps to 0).
- RELEASE: cpu_rst=1, load_ready=0, one cycle only, then RUN.
- RUN: cpu_rst=0 and load_ready=0. Stays in RUN until rst.
- Read path in RUN is combinational with zero latency: the CPU samples data in the same cycle.
  - R=0, addr!=MMIO_ADDR: data_out=ram[addr].
  - R=0, addr==MMIO_ADDR: data_out={2'b0, err, ovf, full, count[2:0]}.
  - R=1: data_out=0.
- Write path in RUN, at posedge:
  - W=0, R=1, addr!=MMIO_ADDR: ram[addr]<=data_in.
  - W=0, R=1, addr==MMIO_ADDR: push data_in into the FIFO; RAM is not written.
- Collision (R=0 and W=0): the write is suppressed (neither RAM nor FIFO), err<=1, and the read is still served.
- FIFO:
  - Circular buffer, OUT_DEPTH entries, count in 0..OUT_DEPTH.
  - out_data = head entry when count>0, else 0. out_valid=(count!=0).
  - Pop occurs when out_valid and out_ready.
  - A push is accepted if count<OUT_DEPTH, or if a pop occurs in the same cycle. Push and pop together leave count unchanged.
  - A push when full with no pop drops the byte and sets ovf<=1; count is unchanged.
  - Bytes leave in write order. Pointers wrap modulo OUT_DEPTH.
- Status bits: err and ovf are sticky until rst. full=(count==OUT_DEPTH).
- Uninitialised RAM reads return whatever the RAM holds; the bench must load every byte it reads.

Test Plan:
- Load bytes C0,63,C2,FF with load_last on the 4th byte -> load_ready is high for 4 cycles, RELEASE lasts 1 cycle, cpu_rst falls; in RUN, R=0 addr=1 gives data_out=63.
- RUN: W=0 addr=10 data_in=5A, next cycle R=0 addr=10 -> data_out=5A. Then R=W=0 addr=10 data_in=11 -> ram[10] stays 5A, err=1, data_out=5A.
- out_ready=0, write 01,02,03,04,05 to FF -> count=4, full=1, ovf=1. Read FF -> data_out=8'h1C. Raise out_ready -> out_data sequence 01,02,03,04, then out_valid=0.
- FIFO full with out_ready=1 and a push of 77 in the same cycle -> count stays 4, ovf unchanged, 77 emerges after the four older bytes.
- Stream 256 bytes without load_last -> ram[0..255] filled, load_ptr wraps to 0, RELEASE then RUN.
- Assert rst mid-load after 3 bytes, release, load 2 bytes with load_last -> cpu_rst held high throughout the load; bytes land at addresses 0 and 1; err=0 and ovf=0.
- LOAD_EN=0: after rst, cpu_rst=0 immediately and load_ready=0.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dCPU memory responder: program loader, 256x8 RAM, MMIO output FIFO
// Holds the CPU in reset while the image streams in, then serves its R/W strobes.
module dmem_responder #(
    parameter int         OUT_DEPTH = 4,
    parameter logic [7:0] MMIO_ADDR = 8'hFF,
    parameter bit         LOAD_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       R,
    input  logic       W,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       cpu_rst,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       err,
    output logic       ovf
);
    localparam int PW = (OUT_DEPTH > 2) ? 2 : 1;

    typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;

    state_t        r_state;
    logic [7:0]    r_load_ptr;
    logic          r_cpu_rst;
    logic          r_load_ready;
    logic          r_err;
    logic          r_ovf;
    logic [7:0]    r_ram [256];
    logic [7:0]    r_fifo [OUT_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [2:0]    r_count;

    logic w_run, w_wr, w_ram_we, w_push, w_pop, w_full, w_push_acc;

    assign w_run      = (r_state == S_RUN);
    // A collision (R and W both low) suppresses the write entirely.
    assign w_wr       = w_run && !W && R;
    assign w_ram_we   = w_wr && (addr != MMIO_ADDR);
    assign w_push     = w_wr && (addr == MMIO_ADDR);
    assign w_pop      = (r_count != 3'd0) && out_ready;
    assign w_full     = (r_count == 3'(OUT_DEPTH));
    assign w_push_acc = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= LOAD_EN ? S_LOAD : S_RUN;
            r_load_ptr   <= 8'd0;
            r_cpu_rst    <= LOAD_EN;
            r_load_ready <= LOAD_EN;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (load_valid) begin
                        r_load_ptr <= r_load_ptr + 8'd1;
                        if (load_last || r_load_ptr == 8'hFF) begin
                            r_state      <= S_RELEASE;
                            r_load_ready <= 1'b0;
                        end
                    end
                end
                S_RELEASE: begin
                    r_state   <= S_RUN;
                    r_cpu_rst <= 1'b0;
                end
                default: begin
                    if (!R && !W) r_err <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_acc) r_tail <= r_tail + 1'b1;
            if (w_pop)      r_head <= r_head + 1'b1;
            if (w_push_acc && !w_pop)      r_count <= r_count + 3'd1;
            else if (!w_push_acc && w_pop) r_count <= r_count - 3'd1;
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Storage arrays are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_push_acc) r_fifo[r_tail] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && load_valid) r_ram[r_load_ptr] <= load_data;
        else if (w_ram_we)                   r_ram[addr]       <= data_in;
    end

    always_comb begin
        data_out = 8'd0;
        if (w_run && !R) begin
            if (addr == MMIO_ADDR) data_out = {2'b00, r_err, r_ovf, w_full, r_count};
            else                   data_out = r_ram[addr];
        end
    end

    assign out_valid  = (r_count != 3'd0);
    assign out_data   = out_valid ? r_fifo[r_head] : 8'd0;
    assign cpu_rst    = r_cpu_rst;
    assign load_ready = r_load_ready;
    assign err        = r_err;
    assign ovf        = r_ovf;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
    logic       clk = 1'b0;
    logic       rst, R, W, load_valid, load_last, out_ready;
    logic [7:0] addr, data_in, load_data;

    logic [7:0] d0_data_out, d0_out_data, d1_data_out, d1_out_data;
    logic       d0_cpu_rst, d0_load_ready, d0_out_valid, d0_err, d0_ovf;
    logic       d1_cpu_rst, d1_load_ready, d1_out_valid, d1_err, d1_ovf;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_responder #(.OUT_DEPTH(4), .MMIO_ADDR(8'hFF), .LOAD_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .R(R), .W(W), .addr(addr), .data_in(data_in),
        .data_out(d0_data_out), .cpu_rst(d0_cpu_rst), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(d0_load_ready),
        .out_valid(d0_out_valid), .out_data(d0_out_data), .out_ready(out_ready),
        .err(d0_err), .ovf(d0_ovf)
    );

    dmem_responder #(.OUT_DEPTH(2), .MMIO_ADDR(8'hFF), .LOAD_EN(1'b0)) u_dut_noload (
        .clk(clk), .rst(rst), .R(R), .W(W), .addr(addr), .data_in(data_in),
        .data_out(d1_data_out), .cpu_rst(d1_cpu_rst), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(d1_load_ready),
        .out_valid(d1_out_valid), .out_data(d1_out_data), .out_ready(out_ready),
        .err(d1_err), .ovf(d1_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic quick_load();
        load_valid = 1'b1; load_data = 8'h00; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        tick();
    endtask

    task automatic push(input logic [7:0] b);
        W = 1'b0; addr = 8'hFF; data_in = b;
        tick();
        W = 1'b1;
    endtask

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    logic [7:0] img [4];

    initial begin
        img[0] = 8'hC0; img[1] = 8'h63; img[2] = 8'hC2; img[3] = 8'hFF;
        rst = 1'b1; R = 1'b1; W = 1'b1; addr = 8'd0; data_in = 8'd0;
        load_valid = 1'b0; load_data = 8'd0; load_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_cpu_rst", d0_cpu_rst, 1);
        chk("rst_load_ready", d0_load_ready, 1);
        chk("rst_out_valid", d0_out_valid, 0);
        chk("rst_out_data", d0_out_data, 0);
        chk("rst_data_out", d0_data_out, 0);
        chk("rst_err", d0_err, 0);
        chk("rst_ovf", d0_ovf, 0);
        chk("noload_rst_cpu_rst", d1_cpu_rst, 0);
        chk("noload_rst_load_ready", d1_load_ready, 0);
        rst = 1'b0;

        // Four-byte image, last flagged on the 4th byte
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = img[i]; load_last = (i == 3);
            #1;
            chk("load_ready_during_load", d0_load_ready, 1);
            chk("cpu_rst_during_load", d0_cpu_rst, 1);
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("release_load_ready", d0_load_ready, 0);
        chk("release_cpu_rst", d0_cpu_rst, 1);
        tick();
        chk("run_cpu_rst", d0_cpu_rst, 0);
        R = 1'b0; addr = 8'd1; #1;
        chk("read_addr1", d0_data_out, 8'h63);
        addr = 8'd3; #1;
        chk("read_addr3", d0_data_out, 8'hFF);
        R = 1'b1; #1;
        chk("idle_data_out", d0_data_out, 0);

        // RAM write, read back, then collision
        W = 1'b0; addr = 8'd10; data_in = 8'h5A;
        tick();
        W = 1'b1; R = 1'b0; #1;
        chk("read_back_5a", d0_data_out, 8'h5A);
        chk("err_before_coll", d0_err, 0);
        W = 1'b0; data_in = 8'h11; #1;
        chk("coll_read_served", d0_data_out, 8'h5A);
        tick();
        chk("coll_err", d0_err, 1);
        W = 1'b1; #1;
        chk("coll_no_write", d0_data_out, 8'h5A);
        R = 1'b1;

        // FIFO overflow and drain
        do_reset();
        chk("err_cleared", d0_err, 0);
        quick_load();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("ovf_set", d0_ovf, 1);
        R = 1'b0; addr = 8'hFF; #1;
        chk("status_full_ovf", d0_data_out, 8'h1C);
        R = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_valid", d0_out_valid, 1);
            chk("drain_data", d0_out_data, 8'(i));
            tick();
        end
        chk("drain_empty_valid", d0_out_valid, 0);
        chk("drain_empty_data", d0_out_data, 0);
        out_ready = 1'b0;

        // Push into a full FIFO while popping
        do_reset();
        quick_load();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        out_ready = 1'b1; W = 1'b0; addr = 8'hFF; data_in = 8'h77; #1;
        chk("full_head", d0_out_data, 8'h11);
        tick();
        W = 1'b1; out_ready = 1'b0; R = 1'b0; #1;
        chk("status_full_no_ovf", d0_data_out, 8'h0C);
        R = 1'b1;
        out_ready = 1'b1;
        chk("simul_drain0", d0_out_data, 8'h22); tick();
        chk("simul_drain1", d0_out_data, 8'h33); tick();
        chk("simul_drain2", d0_out_data, 8'h44); tick();
        chk("simul_drain3", d0_out_data, 8'h77); tick();
        chk("simul_empty", d0_out_valid, 0);
        chk("simul_ovf_clear", d0_ovf, 0);
        out_ready = 1'b0;

        // Full 256-byte image without load_last
        do_reset();
        for (int i = 0; i < 256; i++) begin
            load_valid = 1'b1; load_data = pat(i); load_last = 1'b0;
            if (i == 255) begin
                #1;
                chk("full_load_ready_last", d0_load_ready, 1);
            end
            tick();
        end
        load_valid = 1'b0;
        chk("full_release_ready", d0_load_ready, 0);
        chk("full_release_cpu_rst", d0_cpu_rst, 1);
        tick();
        chk("full_run_cpu_rst", d0_cpu_rst, 0);
        for (int a = 0; a < 255; a++) begin
            R = 1'b0; addr = 8'(a); #1;
            chk("full_image_byte", d0_data_out, pat(a));
        end
        R = 1'b1;

        // Reset in the middle of a load
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = 8'hAA + 8'(i * 17); load_last = 1'b0;
            #1;
            chk("midload_cpu_rst", d0_cpu_rst, 1);
            tick();
        end
        load_valid = 1'b0;
        rst = 1'b1; #1;
        chk("midload_rst_cpu_rst", d0_cpu_rst, 1);
        tick();
        rst = 1'b0;
        load_valid = 1'b1; load_data = 8'hD1; load_last = 1'b0; #1;
        chk("reload_cpu_rst0", d0_cpu_rst, 1);
        tick();
        load_data = 8'hD2; load_last = 1'b1; #1;
        chk("reload_cpu_rst1", d0_cpu_rst, 1);
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("reload_release", d0_cpu_rst, 1);
        tick();
        R = 1'b0; addr = 8'd0; #1;
        chk("reload_addr0", d0_data_out, 8'hD1);
        addr = 8'd1; #1;
        chk("reload_addr1", d0_data_out, 8'hD2);
        addr = 8'd2; #1;
        chk("reload_addr2_kept", d0_data_out, 8'hCC);
        R = 1'b1;
        chk("reload_err", d0_err, 0);
        chk("reload_ovf", d0_ovf, 0);

        // LOAD_EN=0, depth-2 instance; the loading instance ignores strobes
        do_reset();
        chk("noload_cpu_rst", d1_cpu_rst, 0);
        chk("noload_load_ready", d1_load_ready, 0);
        out_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3);
        R = 1'b0; addr = 8'hFF; #1;
        chk("noload_status", d1_data_out, 8'h1A);
        chk("noload_head", d1_out_data, 8'hA1);
        chk("load_state_ignores_read", d0_data_out, 0);
        chk("load_state_ignores_push", d0_out_valid, 0);
        R = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
